// File: rtl/tamagotchi_button_frontend.sv
// Button front end: syncs and debounces three active-low buttons into one-clk commands.
// Latency: DEBOUNCE_CYC+2 clk from the first captured raw low to the registered pulse.
// No backpressure: pulses are fire-and-forget; sleep/awake pass through a lockout window.
module tamagotchi_button_frontend #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_CYC   = 25000000,
  parameter int LOCKOUT_CYC  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_n,
  input  logic       btn_awake_n,
  input  logic       btn_feed_n,
  output logic       sleep_pulse,
  output logic       awake_pulse,
  output logic       feed_pulse,
  output logic [2:0] btn_level,
  output logic       conflict
);

  localparam int CW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RCW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam int LW  = $clog2(LOCKOUT_CYC + 1);

  // Channel index: 0 = sleep, 1 = awake, 2 = feed.
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    sync;
  state_t        state     [3];
  state_t        state_nxt [3];
  logic [CW-1:0] cnt       [3];
  logic [CW-1:0] cnt_nxt   [3];
  logic [2:0]    press_cand;
  logic [2:0]    level_nxt;
  logic [RCW-1:0] rcnt;
  logic [RCW-1:0] rcnt_nxt;
  logic          rep_cand;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_nxt;
  logic          lock_active;
  logic          sleep_nxt;
  logic          awake_nxt;
  logic          feed_nxt;
  logic          conflict_nxt;

  assign raw  = {btn_feed_n, btn_awake_n, btn_sleep_n};
  assign sync = ~sync2;

  // Two-flop synchronizer, preset to released so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM state and stability counters for all three channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Debounce next-state: a level must hold DEBOUNCE_CYC+1 samples to be accepted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      press_cand[i] = 1'b0;
      case (state[i])
        RELEASED: begin
          if (sync[i]) begin
            state_nxt[i] = PRESS_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync[i]) begin
            state_nxt[i] = RELEASED;
          end else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
            state_nxt[i]  = PRESSED;
            press_cand[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync[i]) begin
            state_nxt[i] = RELEASE_WAIT;
            cnt_nxt[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync[i]) begin
            state_nxt[i] = PRESSED;
          end else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
            state_nxt[i] = RELEASED;
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end
        default: state_nxt[i] = RELEASED;
      endcase
      level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_WAIT);
    end
  end

  // Feed auto-repeat: count held cycles, restart the phase whenever PRESSED is (re)entered.
  always_comb begin
    rcnt_nxt = rcnt;
    rep_cand = 1'b0;
    if ((state[2] == PRESSED) || (state[2] == RELEASE_WAIT)) begin
      if (rcnt == RCW'(REPEAT_CYC - 1)) begin
        rep_cand = 1'b1;
        rcnt_nxt = '0;
      end else begin
        rcnt_nxt = rcnt + RCW'(1);
      end
    end
    if ((state_nxt[2] == PRESSED) && (state[2] != PRESSED)) begin
      rcnt_nxt = '0;
    end
  end

  assign lock_active = (lock_cnt != '0);

  // Arbitration: feed always passes; sleep/awake collide or are rate-limited by lockout.
  always_comb begin
    sleep_nxt    = 1'b0;
    awake_nxt    = 1'b0;
    conflict_nxt = 1'b0;
    feed_nxt     = press_cand[2] | rep_cand;
    lock_nxt     = lock_active ? (lock_cnt - LW'(1)) : '0;
    if (press_cand[0] && press_cand[1]) begin
      conflict_nxt = 1'b1;
    end else if ((press_cand[0] || press_cand[1]) && !lock_active) begin
      sleep_nxt = press_cand[0];
      awake_nxt = press_cand[1];
      lock_nxt  = LW'(LOCKOUT_CYC - 1);
    end
  end

  // Register every output so nothing combinational reaches the pet state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt        <= '0;
      lock_cnt    <= '0;
      sleep_pulse <= 1'b0;
      awake_pulse <= 1'b0;
      feed_pulse  <= 1'b0;
      conflict    <= 1'b0;
      btn_level   <= 3'b000;
    end else begin
      rcnt        <= rcnt_nxt;
      lock_cnt    <= lock_nxt;
      sleep_pulse <= sleep_nxt;
      awake_pulse <= awake_nxt;
      feed_pulse  <= feed_nxt;
      conflict    <= conflict_nxt;
      btn_level   <= level_nxt;
    end
  end

endmodule

// File: doc/tamagotchi_button_frontend.md
Name: tamagotchi_button_frontend

Overview:
- Input-side partner of the pet state machine. It turns three raw, bouncing, active-low push-buttons (sleep, awake, feed) into clean single-cycle command pulses on the system clock.
- Feed auto-repeats while held. Sleep and awake are arbitrated against each other and rate-limited.
- Outputs connect directly to the state machine's sleep, awake and feed inputs. Debounced levels are also exported for LEDs and debug.

Parameters:
- DEBOUNCE_CYC, 50000, clk cycles a synchronized level must stay stable before it is accepted (1 ms at 50 MHz).
- REPEAT_CYC, 25000000, clk cycles between feed auto-repeat pulses while feed is held.
- LOCKOUT_CYC, 5000000, clk cycles after an emitted sleep or awake pulse during which further sleep/awake pulses are suppressed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_sleep_n  in  1  raw sleep button, active-low, asynchronous to clk.
- btn_awake_n  in  1  raw awake button, active-low, asynchronous to clk.
- btn_feed_n  in  1  raw feed button, active-low, asynchronous to clk.
- sleep_pulse  out  1  one-clk sleep command.
- awake_pulse  out  1  one-clk awake command.
- feed_pulse  out  1  one-clk feed command.
- btn_level  out  3  debounced pressed levels {feed, awake, sleep}, 1 = pressed.
- conflict  out  1  one-clk flag: sleep and awake were accepted in the same cycle.

Behaviour:
- Reset: all outputs 0. Synchronizer flops preset to 1 (released). Channel FSMs go to RELEASED. All counters 0. Lockout inactive. Reset may assert at any time; all pending pulses and counts are discarded.
- Synchronizer: each raw input passes through 2 flops. The "sync" signal is the inverted second flop (1 = pressed).
- Per-channel FSM, with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, and counter cnt of width $clog2(DEBOUNCE_CYC+1):
  - RELEASED: sync=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: sync=0 -> RELEASED (bounce rejected). Otherwise cnt++. When cnt==DEBOUNCE_CYC-1 -> PRESSED, and a candidate press is raised that cycle.
  - PRESSED: sync=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: sync=1 -> PRESSED (no new candidate). Otherwise cnt++. When cnt==DEBOUNCE_CYC-1 -> RELEASED.
- btn_level bit = 1 in PRESSED and RELEASE_WAIT.
- Latency: a raw low first captured at edge k gives a registered pulse high from edge k+DEBOUNCE_CYC+2, for exactly one cycle. A glitch shorter than DEBOUNCE_CYC cycles after synchronization produces no pulse.
- Feed auto-repeat:
  - Repeat counter rcnt ($clog2(REPEAT_CYC) bits) clears on entry to PRESSED and increments while in PRESSED or RELEASE_WAIT.
  - At rcnt==REPEAT_CYC-1: feed candidate raised and rcnt wraps to 0.
  - Continuous hold of H cycles after acceptance yields 1+floor(H/REPEAT_CYC) pulses.
  - Sleep and awake never repeat.
- Arbitration, applied to the candidates then registered:
  - Feed candidate always passes; it is independent of lockout and conflict.
  - Sleep and awake candidates in the same cycle: both dropped, conflict=1 for that cycle, lockout not started.
  - Exactly one of sleep/awake candidates with lockout inactive: the pulse is emitted and the lockout counter loads LOCKOUT_CYC-1.
  - Candidate while lockout active: dropped silently. It is not queued and does not retrigger lockout.
  - Lockout counter decrements to 0. Lockout is active while the counter is nonzero, or on the load cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- At most one pulse per output per clk. Pulse outputs are never high for 2 consecutive cycles.

Test Plan (DEBOUNCE_CYC=4, REPEAT_CYC=10, LOCKOUT_CYC=6):
- Clean press: btn_feed_n low at edge 0, held 30 cycles -> feed_pulse high only at edge 6. btn_level[2] high from edge 6. Further pulses at edges 16 and 26.
- Bounce: btn_sleep_n toggles low 2 cycles / high 1 cycle ×5, then low stable -> no pulse during the bounce. Exactly one sleep_pulse, 6 edges after the final falling edge.
- Conflict: sleep and awake released from reset in the same cycle and held -> conflict=1 for one cycle. sleep_pulse and awake_pulse stay 0. btn_level=3'b011.
- Lockout: sleep accepted at edge 6, then awake pressed so its candidate lands at edge 9 -> awake_pulse stays 0. Awake re-pressed with its candidate at edge 14 -> awake_pulse=1.
- Feed during lockout: feed candidate at edge 8 while lockout is active -> feed_pulse=1 at edge 8.
- Reset mid-debounce: rst pulsed while btn_awake_n is low in PRESS_WAIT with cnt=2 -> all outputs 0. After release of rst, a full DEBOUNCE_CYC+2 cycles are required before awake_pulse.
